// File: rtl/riscv_wb_pkg.sv
// Shared widths, writeback request payload and register mask helper for the writeback stage.
package riscv_wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREG   = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // One-hot register mask; x0 is never tracked.
    function automatic logic [NREG-1:0] reg_onehot(input logic [REG_AW-1:0] rd);
        logic [NREG-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        m[0]  = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer of long-latency writeback results with wrap-around pointers and an occupancy count.
module wb_result_fifo
    import riscv_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head_c,
    output logic    full_c,
    output logic    empty_c
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_req_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_c  = mem[rd_ptr];
    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback stage: per-register pending scoreboard, ALU/long-latency merge and registered RF write port.
module wb_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              issue_valid,
    input  logic [riscv_wb_pkg::REG_AW-1:0]   issue_rs1,
    input  logic [riscv_wb_pkg::REG_AW-1:0]   issue_rs2,
    input  logic [riscv_wb_pkg::REG_AW-1:0]   issue_rd,
    input  logic                              issue_rd_we,
    output logic                              issue_stall,
    input  logic                              alu_valid,
    input  logic [riscv_wb_pkg::REG_AW-1:0]   alu_rd,
    input  logic [XLEN-1:0]                   alu_data,
    input  logic                              lu_valid,
    output logic                              lu_ready,
    input  logic [riscv_wb_pkg::REG_AW-1:0]   lu_rd,
    input  logic [XLEN-1:0]                   lu_data,
    output logic                              rf_we,
    output logic [riscv_wb_pkg::REG_AW-1:0]   rf_rd,
    output logic [XLEN-1:0]                   rf_wdata,
    output logic [NREG-1:0]                   busy,
    output logic                              wb_err
);

    typedef riscv_wb_pkg::wb_req_t req_t;

    req_t            lu_req;
    req_t            lu_head;
    req_t            cand;
    logic            cand_valid;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            accept;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] busy_next;

    assign lu_req = '{rd: lu_rd, data: lu_data};

    wb_result_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (lu_req),
        .pop       (pop),
        .head_c    (lu_head),
        .full_c    (fifo_full),
        .empty_c   (fifo_empty)
    );

    // Hazard check: any pending source or (for writers) pending destination stalls issue.
    assign issue_stall = issue_valid &&
                         (busy[issue_rs1] || busy[issue_rs2] || (issue_rd_we && busy[issue_rd]));
    assign accept      = issue_valid && !issue_stall;
    assign lu_ready    = !fifo_full;
    assign push        = lu_valid && lu_ready;
    assign pop         = !alu_valid && !fifo_empty;

    // ALU has fixed priority on the single write port.
    always_comb begin
        cand       = lu_head;
        cand_valid = !fifo_empty;
        if (alu_valid) begin
            cand       = '{rd: alu_rd, data: alu_data};
            cand_valid = 1'b1;
        end
    end

    // Commit clears and issue sets; set wins if both hit the same bit.
    always_comb begin
        set_mask  = '0;
        clr_mask  = '0;
        if (accept && issue_rd_we) set_mask = NREG'(riscv_wb_pkg::reg_onehot(issue_rd));
        if (rf_we)                 clr_mask = NREG'(riscv_wb_pkg::reg_onehot(rf_rd));
        busy_next = (busy & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= '0;
            wb_err <= 1'b0;
        end else begin
            busy <= busy_next;
            if (rf_we && (rf_rd != '0) && !busy[rf_rd]) wb_err <= 1'b1;
        end
    end

    // x0 candidates are consumed without asserting the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= 1'b0;
            if (cand_valid && (cand.rd != '0)) begin
                rf_we    <= 1'b1;
                rf_rd    <= cand.rd;
                rf_wdata <= cand.data;
            end
        end
    end

endmodule
